// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR output decimator slice.
// Holds default widths, the sample typedefs, the FSM state enum and saturation helpers.
package fir_pkg;

  localparam int DEF_BIT_WIDTH  = 16;
  localparam int DEF_OUT_WIDTH  = 12;
  localparam int DEF_DECIM      = 4;
  localparam int DEF_FILL_SKIP  = 9;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef logic signed [DEF_BIT_WIDTH-1:0] sample_t;
  typedef logic signed [DEF_OUT_WIDTH-1:0] out_sample_t;

  typedef enum logic {
    FILL,
    RUN
  } state_t;

  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int sat_min(input int width);
    return -(1 << (width - 1));
  endfunction

  localparam int OUT_SAT_MAX = sat_max(DEF_OUT_WIDTH);
  localparam int OUT_SAT_MIN = sat_min(DEF_OUT_WIDTH);

endpackage

// File: rtl/fir_sample_fifo.sv
// Small synchronous FIFO with first-word fall-through output and async active-low reset.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module fir_sample_fifo
  import fir_pkg::*;
#(
  parameter int WIDTH = DEF_OUT_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Empty FIFO presents zero so a reset also clears the visible head.
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fir_output_decimator.sv
// FIR output stage: drops the pipeline-fill transient, keeps every DECIM-th sample,
// rounds/saturates to OUT_WIDTH and streams it out of a FIFO. Define DECIM_STATS_EN for drop_count.
module fir_output_decimator
  import fir_pkg::*;
#(
  parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int DECIM      = DEF_DECIM,
  parameter int FILL_SKIP  = DEF_FILL_SKIP,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic signed [BIT_WIDTH-1:0]   y_in,
  output logic signed [OUT_WIDTH-1:0]   m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
`ifdef DECIM_STATS_EN
  ,
  output logic [15:0]                   drop_count
`endif
);

  localparam int SH      = BIT_WIDTH - OUT_WIDTH;
  localparam int W1      = BIT_WIDTH + 1;
  localparam int SKIP_W  = (FILL_SKIP > 0) ? $clog2(FILL_SKIP + 1) : 1;
  localparam int PHASE_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int RND_INT = (SH > 0) ? (1 << (SH - 1)) : 0;

  localparam logic signed [BIT_WIDTH:0] RND    = W1'(RND_INT);
  localparam logic signed [BIT_WIDTH:0] SAT_HI = W1'(sat_max(OUT_WIDTH));
  localparam logic signed [BIT_WIDTH:0] SAT_LO = W1'(sat_min(OUT_WIDTH));
  localparam logic [SKIP_W-1:0]  SKIP_LAST  = SKIP_W'(FILL_SKIP - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DECIM - 1);
  localparam state_t             RESET_STATE = (FILL_SKIP == 0) ? RUN : FILL;

  state_t                 state_q, state_d;
  logic [SKIP_W-1:0]      skip_q, skip_d;
  logic [PHASE_W-1:0]     phase_q, phase_d;
  logic                   keep;

  logic signed [BIT_WIDTH:0]   rnd_sum, shifted;
  logic signed [OUT_WIDTH-1:0] stage_data_q, stage_data_d;
  logic                        stage_valid_q;

  logic                 fifo_full, fifo_empty, pop, drop;
  logic [OUT_WIDTH-1:0] fifo_dout;
  logic                 overflow_q;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    phase_d = phase_q;
    keep    = 1'b0;
    if (enable) begin
      case (state_q)
        FILL: begin
          skip_d = skip_q + SKIP_W'(1);
          if (skip_q == SKIP_LAST) begin
            state_d = RUN;
            phase_d = '0;
          end
        end
        RUN: begin
          keep    = (phase_q == '0);
          phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PHASE_W'(1);
        end
        default: state_d = RESET_STATE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_STATE;
      skip_q  <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      phase_q <= phase_d;
    end
  end

  // One extra bit of headroom keeps the half-LSB add from wrapping at full scale.
  always_comb begin
    rnd_sum = $signed({y_in[BIT_WIDTH-1], y_in}) + RND;
    shifted = rnd_sum >>> SH;
    if (shifted > SAT_HI)      stage_data_d = SAT_HI[OUT_WIDTH-1:0];
    else if (shifted < SAT_LO) stage_data_d = SAT_LO[OUT_WIDTH-1:0];
    else                       stage_data_d = shifted[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
    end else begin
      stage_valid_q <= keep;
      if (keep) stage_data_q <= stage_data_d;
    end
  end

  assign pop  = m_valid & m_ready;
  assign drop = stage_valid_q & fifo_full & ~pop;

  fir_sample_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (stage_valid_q),
    .pop   (pop),
    .din   (stage_data_q),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_valid = ~fifo_empty;
  assign m_data  = fifo_dout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
  end

  assign overflow = overflow_q;

`ifdef DECIM_STATS_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_cnt_q <= '0;
    else if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fir_output_decimator.sv
// Self-checking bench for fir_output_decimator: a queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed sequences. Honours DECIM_STATS_EN.
module tb_fir_output_decimator;
  import fir_pkg::*;

  localparam int SH    = DEF_BIT_WIDTH - DEF_OUT_WIDTH;
  localparam int DEPTH = DEF_FIFO_DEPTH;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        m_ready = 1'b0;
  sample_t     y_in = '0;
  out_sample_t m_data;
  logic        m_valid;
  logic        overflow;
  logic [$clog2(DEF_FIFO_DEPTH):0] fifo_count;
`ifdef DECIM_STATS_EN
  logic [15:0] drop_count;
`endif

  int checks = 0;
  int failures = 0;

  int mq[$];
  int outQ[$];
  int expQ[$];
  bit stValid = 1'b0;
  int stVal = 0;
  int enCnt = 0;
  bit mOvf = 1'b0;
  int mDrops = 0;
  bit popNow;

  fir_output_decimator #(
    .BIT_WIDTH  (DEF_BIT_WIDTH),
    .OUT_WIDTH  (DEF_OUT_WIDTH),
    .DECIM      (DEF_DECIM),
    .FILL_SKIP  (DEF_FILL_SKIP),
    .FIFO_DEPTH (DEF_FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .y_in       (y_in),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow)
`ifdef DECIM_STATS_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Round half up then floor-divide by 2^SH, clamp to the output range.
  function automatic int narrowModel(input int y);
    int v;
    int d;
    int q;
    d = 1 << SH;
    v = y + ((SH > 0) ? (d / 2) : 0);
    if (v >= 0) q = v / d;
    else        q = -((-v + d - 1) / d);
    if (q > OUT_SAT_MAX) q = OUT_SAT_MAX;
    if (q < OUT_SAT_MIN) q = OUT_SAT_MIN;
    return q;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit en, input int y, input bit rdy);
    @(negedge clk);
    enable  = en;
    y_in    = sample_t'(y);
    m_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic keepGroup(input int y, input bit rdy);
    applyStimulus(1'b1, y, rdy);
    repeat (DEF_DECIM - 1) applyStimulus(1'b1, 0, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) applyStimulus(1'b0, 0, rdy);
  endtask

  task automatic checkSeq(input string name);
    checkOutput({name, "_len"}, outQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < outQ.size(); i++)
      checkOutput(name, outQ[i], expQ[i]);
    outQ.delete();
    expQ.delete();
  endtask

  // Reference model: sample index decides keep, a queue stands in for the FIFO.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      stValid = 1'b0;
      enCnt   = 0;
      mOvf    = 1'b0;
      mDrops  = 0;
    end else begin
      popNow = (mq.size() != 0) && m_ready;
      if (popNow) outQ.push_back(mq.pop_front());
      if (stValid) begin
        if (mq.size() < DEPTH) mq.push_back(stVal);
        else begin
          mOvf = 1'b1;
          mDrops++;
        end
      end
      stValid = 1'b0;
      if (enable) begin
        enCnt++;
        if (enCnt > DEF_FILL_SKIP && ((enCnt - DEF_FILL_SKIP - 1) % DEF_DECIM) == 0) begin
          stValid = 1'b1;
          stVal   = narrowModel(int'(y_in));
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset) begin
      checkOutput("fifo_count", int'(fifo_count), mq.size());
      checkOutput("m_valid", int'(m_valid), int'(mq.size() != 0));
      checkOutput("overflow", int'(overflow), int'(mOvf));
      if (mq.size() != 0) checkOutput("m_data", int'(m_data), mq[0]);
`ifdef DECIM_STATS_EN
      checkOutput("drop_count", int'(drop_count), (mDrops > 65535) ? 65535 : mDrops);
`endif
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_m_valid", int'(m_valid), 0);
    checkOutput("rst_fifo_count", int'(fifo_count), 0);
    checkOutput("rst_m_data", int'(m_data), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    @(negedge clk);
    reset = 1'b1;

    // Basic decimation and latency.
    for (int k = 1; k <= 21; k++) begin
      applyStimulus(1'b1, 16 * k, 1'b1);
      if (k == 10) checkOutput("lat_k10_valid", int'(m_valid), 0);
      if (k == 11) begin
        checkOutput("lat_k11_valid", int'(m_valid), 1);
        checkOutput("lat_k11_data", int'(m_data), 10);
      end
    end
    idle(4, 1'b1);
    expQ = '{10, 14, 18};
    checkSeq("decim_seq");

    // Rounding and saturation corners.
    keepGroup(32'h7FFF, 1'b1);
    keepGroup(-32768, 1'b1);
    keepGroup(-8, 1'b1);
    keepGroup(-9, 1'b1);
    keepGroup(24, 1'b1);
    idle(4, 1'b1);
    expQ = '{2047, -2048, 0, -1, 2};
    checkSeq("round_sat");

    // Mid-stream reset with three buffered entries.
    keepGroup(16, 1'b0);
    keepGroup(32, 1'b0);
    keepGroup(48, 1'b0);
    idle(1, 1'b0);
    checkOutput("pre_rst_count", int'(fifo_count), 3);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midrst_m_valid", int'(m_valid), 0);
    checkOutput("midrst_fifo_count", int'(fifo_count), 0);
    checkOutput("midrst_m_data", int'(m_data), 0);
    @(negedge clk);
    reset = 1'b1;
    outQ.delete();

    // Enable gaps after reset: fill discard again, same kept set.
    for (int k = 1; k <= 21; k++) begin
      applyStimulus(1'b1, 16 * k, 1'b1);
      applyStimulus(1'b0, 5000, 1'b1);
    end
    idle(4, 1'b1);
    expQ = '{10, 14, 18};
    checkSeq("toggle_seq");

    // Full FIFO with simultaneous pop and push.
    for (int v = 101; v <= 108; v++) keepGroup(16 * v, 1'b0);
    idle(1, 1'b0);
    checkOutput("t6_full_count", int'(fifo_count), 8);
    applyStimulus(1'b1, 16 * 109, 1'b0);
    applyStimulus(1'b1, 0, 1'b1);
    checkOutput("t6_count_held", int'(fifo_count), 8);
    checkOutput("t6_no_overflow", int'(overflow), 0);
    applyStimulus(1'b1, 0, 1'b0);
    applyStimulus(1'b1, 0, 1'b0);
    idle(12, 1'b1);
    expQ = '{101, 102, 103, 104, 105, 106, 107, 108, 109};
    checkSeq("t6_seq");
    checkOutput("t6_drained", int'(fifo_count), 0);

    // Overflow: ninth kept sample is lost.
    for (int v = 1; v <= 9; v++) keepGroup(16 * v, 1'b0);
    idle(2, 1'b0);
    checkOutput("ovf_count", int'(fifo_count), 8);
    checkOutput("ovf_flag", int'(overflow), 1);
`ifdef DECIM_STATS_EN
    checkOutput("ovf_drop_count", int'(drop_count), 1);
`endif
    idle(12, 1'b1);
    expQ = '{1, 2, 3, 4, 5, 6, 7, 8};
    checkSeq("ovf_seq");
    checkOutput("ovf_drained", int'(fifo_count), 0);
    checkOutput("ovf_sticky", int'(overflow), 1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
